// File: rtl/fp32_pkg.sv
// Purpose : shared encodings for the FP32 adder stages (FSM states, exponent limits,
//           mantissa field positions, rounding-mode codes for the downstream rounder).
// Latency : n/a (declarations only).  Backpressure: n/a.
package fp32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] EXP_MAX  = 8'd255;
  localparam logic [7:0] EXP_BIAS = 8'd127;

  // Field positions inside the 26-bit raw magnitude.
  localparam int CARRY_BIT  = 25;
  localparam int HIDDEN_BIT = 24;

  // Rounding modes consumed by the rounder that follows the normalizer.
  localparam logic [1:0] RUP   = 2'b00;
  localparam logic [1:0] RDOWN = 2'b01;
  localparam logic [1:0] RTE   = 2'b10;
  localparam logic [1:0] RTAZ  = 2'b11;

endpackage

// File: rtl/fp32_normalize_if.sv
// Purpose : operand (in_*) and normalized-result (out_*) handshake bundle of the normalizer.
// Latency : n/a (wiring only).  Backpressure: valid/ready on both sides.
// Ports   : master = environment (drives operands and out_ready); slave = the normalizer.
interface fp32_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [25:0] in_mag;

  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_m_norm;
  logic        out_uf;
  logic        out_of;

  modport master (
    output in_valid, in_sign, in_exp, in_mag, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_m_norm, out_uf, out_of
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mag, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_m_norm, out_uf, out_of
  );
endinterface

// File: rtl/fp32_lzc_window.sv
// Purpose : leading-zero count of a STEP-bit window, saturating at STEP when all zero.
// Latency : combinational.  Backpressure: n/a.
// Ports   : win_i window (MSB first), lz_o count 0..STEP.
module fp32_lzc_window #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0] win_i,
  output logic [3:0]      lz_o
);

  // Scan upward so the most significant set bit is the last one to write lz_o.
  always_comb begin
    lz_o = 4'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (win_i[i]) lz_o = 4'(STEP - 1 - i);
    end
  end

endmodule

// File: rtl/fp32_normalize.sv
// Purpose : normalizes the raw 26-bit add/sub magnitude into sign/exp/M_NORM for the rounder.
// Latency : 2 cycles accept-to-valid with no left shift, +1 per left-shift step (<= STEP bits each).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports   : clk, rst (sync, active-high), bus (fp32_normalize_if.slave).
module fp32_normalize #(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  fp32_normalize_if.slave   bus
);
  import fp32_pkg::*;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [8:0]  exp_q, exp_d;        // 9 bits so +1 / -k never wrap
  logic [25:0] mag_q, mag_d;
  logic [7:0]  oexp_q, oexp_d;
  logic [23:0] m_norm_q, m_norm_d;
  logic        uf_q, uf_d;
  logic        of_q, of_d;

  logic [3:0]  lz_w;
  logic [8:0]  lz9, exp_m1, k9, exp_inc;
  logic [25:0] mag_sh;

  fp32_lzc_window #(.STEP(STEP)) u_lzc (
    .win_i (mag_q[HIDDEN_BIT -: STEP]),
    .lz_o  (lz_w)
  );

  // lz already saturates at STEP, so only the exponent floor can further limit k.
  assign lz9     = {5'd0, lz_w};
  assign exp_m1  = exp_q - 9'd1;
  assign k9      = (exp_m1 < lz9) ? exp_m1 : lz9;
  assign exp_inc = exp_q + 9'd1;
  assign mag_sh  = mag_q >> 1;      // old bit1 becomes the round bit, old bit0 dropped

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mag_d    = mag_q;
    oexp_d   = oexp_q;
    m_norm_d = m_norm_q;
    uf_d     = uf_q;
    of_d     = of_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          mag_d  = bus.in_mag;
          exp_d  = (bus.in_exp == 8'd0) ? 9'd1 : {1'b0, bus.in_exp};
          if (bus.in_exp == EXP_MAX) begin
            // Inf/NaN operands bypass normalization untouched.
            oexp_d   = EXP_MAX;
            m_norm_d = bus.in_mag[23:0];
            uf_d     = 1'b0;
            of_d     = 1'b0;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (mag_q == 26'd0) begin
          oexp_d   = 8'd0;
          m_norm_d = 24'd0;
          uf_d     = 1'b0;
          of_d     = 1'b0;
          state_d  = ST_DONE;
        end else if (mag_q[CARRY_BIT]) begin
          uf_d    = 1'b0;
          state_d = ST_DONE;
          if (exp_inc == {1'b0, EXP_MAX}) begin
            oexp_d   = EXP_MAX;
            m_norm_d = 24'd0;
            of_d     = 1'b1;
          end else begin
            oexp_d   = exp_inc[7:0];
            m_norm_d = mag_sh[23:0];
            of_d     = 1'b0;
          end
        end else if (mag_q[HIDDEN_BIT]) begin
          oexp_d   = exp_q[7:0];
          m_norm_d = mag_q[23:0];
          uf_d     = 1'b0;
          of_d     = 1'b0;
          state_d  = ST_DONE;
        end else if (exp_q <= 9'd1) begin
          // Exponent floor reached before the hidden bit: subnormal result.
          oexp_d   = 8'd0;
          m_norm_d = mag_q[23:0];
          uf_d     = 1'b1;
          of_d     = 1'b0;
          state_d  = ST_DONE;
        end else begin
          mag_d = mag_q << k9;
          exp_d = exp_q - k9;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 9'd0;
      mag_q    <= 26'd0;
      oexp_q   <= 8'd0;
      m_norm_q <= 24'd0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mag_q    <= mag_d;
      oexp_q   <= oexp_d;
      m_norm_q <= m_norm_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.out_sign   = sign_q;
  assign bus.out_exp    = oexp_q;
  assign bus.out_m_norm = m_norm_q;
  assign bus.out_uf     = uf_q;
  assign bus.out_of     = of_q;

endmodule

// File: tb/tb_fp32_normalize.sv
// Purpose : directed table-driven checks of fp32_normalize (STEP=4) plus backpressure/reset sequences.
// Latency : edges counted from the accept edge until out_valid is seen.
// Backpressure: out_ready held low while results are inspected.
module tb_fp32_normalize;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  fp32_normalize_if bus ();

  fp32_normalize #(.STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp_in;
    logic [25:0] mag;
    logic [7:0]  exp_out;
    logic [23:0] m_norm;
    logic        uf;
    logic        of;
    int          lat;     // edges after the accept edge before out_valid is visible
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand, accept it, and return how many edges until out_valid.
  task automatic launch(input logic s, input logic [7:0] e, input logic [25:0] m, output int lat);
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mag   = m;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    chk({v.name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    launch(v.sign, v.exp_in, v.mag, lat);
    chk({v.name, ".latency"}, 32'(lat),            32'(v.lat));
    chk({v.name, ".sign"},    32'(bus.out_sign),   32'(v.sign));
    chk({v.name, ".exp"},     32'(bus.out_exp),    32'(v.exp_out));
    chk({v.name, ".m_norm"},  32'(bus.out_m_norm), 32'(v.m_norm));
    chk({v.name, ".uf"},      32'(bus.out_uf),     32'(v.uf));
    chk({v.name, ".of"},      32'(bus.out_of),     32'(v.of));
    release_out();
    chk({v.name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;

    //          name         sign exp     mag            exp_out m_norm       uf    of    lat
    vecs[0] = '{"normal",    1'b0, 8'd127, 26'h1000000, 8'd127, 24'h000000, 1'b0, 1'b0, 1};
    vecs[1] = '{"carry",     1'b0, 8'd127, 26'h3000001, 8'd128, 24'h800000, 1'b0, 1'b0, 1};
    vecs[2] = '{"lshift10",  1'b0, 8'd100, 26'h0004000, 8'd90,  24'h000000, 1'b0, 1'b0, 4};
    vecs[3] = '{"subnorm",   1'b0, 8'd3,   26'h0000100, 8'd0,   24'h000400, 1'b1, 1'b0, 2};
    vecs[4] = '{"overflow",  1'b0, 8'd254, 26'h2000000, 8'd255, 24'h000000, 1'b0, 1'b1, 1};
    vecs[5] = '{"passthru",  1'b1, 8'd255, 26'h2ABCDEF, 8'd255, 24'hABCDEF, 1'b0, 1'b0, 0};
    vecs[6] = '{"exp0as1",   1'b1, 8'd0,   26'h0800000, 8'd0,   24'h800000, 1'b1, 1'b0, 1};
    vecs[7] = '{"expfloor",  1'b1, 8'd10,  26'h0000003, 8'd0,   24'h000600, 1'b1, 1'b0, 4};
    vecs[8] = '{"carryrnd",  1'b0, 8'd5,   26'h2000003, 8'd6,   24'h000001, 1'b0, 1'b0, 1};
    vecs[9] = '{"lzclip",    1'b0, 8'd20,  26'h0FFFFFF, 8'd19,  24'hFFFFFE, 1'b0, 1'b0, 2};

    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd0;
    bus.in_mag    = 26'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset.in_ready",  32'(bus.in_ready),   32'd1);
    chk("reset.out_valid", 32'(bus.out_valid),  32'd0);
    chk("reset.out_sign",  32'(bus.out_sign),   32'd0);
    chk("reset.out_exp",   32'(bus.out_exp),    32'd0);
    chk("reset.out_m_norm",32'(bus.out_m_norm), 32'd0);
    chk("reset.out_uf",    32'(bus.out_uf),     32'd0);
    chk("reset.out_of",    32'(bus.out_of),     32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero magnitude, then hold the result under backpressure.
    launch(1'b1, 8'd50, 26'd0, lat);
    chk("zero.latency", 32'(lat),            32'd1);
    chk("zero.exp",     32'(bus.out_exp),    32'd0);
    chk("zero.m_norm",  32'(bus.out_m_norm), 32'd0);
    chk("zero.uf",      32'(bus.out_uf),     32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp.out_sign",  32'(bus.out_sign),  32'd1);
      chk("bp.out_exp",   32'(bus.out_exp),   32'd0);
    end
    chk("bp.in_ready_before_hs", 32'(bus.in_ready), 32'd0);
    release_out();
    chk("bp.in_ready_after_hs",  32'(bus.in_ready),  32'd1);
    chk("bp.out_valid_after_hs", 32'(bus.out_valid), 32'd0);

    // A long shift interrupted by reset must vanish without a result.
    bus.in_sign  = 1'b1;
    bus.in_exp   = 8'd100;
    bus.in_mag   = 26'h0000001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("abort.in_ready_busy", 32'(bus.in_ready), 32'd0);
    tick();
    chk("abort.no_valid_yet",  32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.in_ready",   32'(bus.in_ready),   32'd1);
    chk("abort.out_valid",  32'(bus.out_valid),  32'd0);
    chk("abort.out_sign",   32'(bus.out_sign),   32'd0);
    chk("abort.out_exp",    32'(bus.out_exp),    32'd0);
    chk("abort.out_m_norm", 32'(bus.out_m_norm), 32'd0);
    chk("abort.out_uf",     32'(bus.out_uf),     32'd0);
    chk("abort.out_of",     32'(bus.out_of),     32'd0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    chk("abort.valid_pulses", 32'(pulses), 32'd0);

    // Block must still work after the aborted operation.
    run_vec(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fp32_normalize.md
Name: fp32_normalize

Overview:
- Producer side of the FP32 adder's normalized-mantissa interface: the stage that drives the rounding stage's S / M_NORM inputs.
- Takes the raw 26-bit sum magnitude and exponent from the add/sub datapath and normalizes it with an iterative multi-cycle shifter.
- Emits sign, biased exponent and a 24-bit M_NORM word (bits [23:1] fraction, bit [0] round bit), plus under/overflow flags.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- STEP, 4, maximum left-shift distance per SHIFT cycle (legal values 1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign.
- in_exp  in  8  biased exponent before normalization.
- in_mag  in  26  [25] carry, [24] hidden, [23:1] fraction, [0] round.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream (rounder) accepts.
- out_sign  out  1  result sign, drives rounder S.
- out_exp  out  8  normalized biased exponent.
- out_m_norm  out  24  [23:1] fraction, [0] round bit, drives rounder M_NORM.
- out_uf  out  1  result is subnormal or zero from nonzero input.
- out_of  out  1  exponent overflowed to 255.

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; out_sign=0; out_exp=0; out_m_norm=0; out_uf=0; out_of=0.
- Reset mid-operation aborts the operation and produces no output.
- States are IDLE, SHIFT and DONE.
- IDLE, in_valid&in_ready: capture sign, exp and mag, then go to SHIFT. Captured in_exp=0 is treated as 1.
- IDLE, in_exp=255: pass the operand through unchanged (mag[23:0] to m_norm) via DONE. Flags are 0.
- SHIFT evaluates once per cycle, in priority order:
  1. mag==0: exp=0, uf=0, go to DONE.
  2. mag[25]=1: mag>>=1 (old bit0 discarded, new round bit = old bit1), exp+=1, go to DONE. If the new exp==255: m_norm=0, of=1.
  3. mag[24]=1: go to DONE.
  4. exp<=1: exp=0, uf=1, go to DONE (subnormal; mag unshifted).
  5. Otherwise: k = min(leading zeros of mag[24:24-STEP+1], STEP, exp-1); mag<<=k; exp-=k; stay in SHIFT.
- DONE: out_valid=1. Outputs are registered and stable while out_valid&!out_ready.
- DONE, out_valid&out_ready: go to IDLE. in_ready rises the next cycle; there is no same-cycle turnaround.
- Latency: accept at edge T; a zero-shift result gives out_valid at T+2. Each left-shift cycle adds 1, so N left shifts add ceil-style steps bounded by STEP per cycle.
- No sticky bit is tracked. Only the single round bit is produced, matching the rounder's M_NORM format.
- Width rules:
  - The exponent is computed in 9 bits internally, so the exponent never wraps.
  - The left shift never drops a set bit, because k ≤ leading zeros.

Decomposition:
- Shared package fp32_pkg holds:
  - state encoding (IDLE/SHIFT/DONE);
  - EXP_MAX=8'd255, EXP_BIAS=8'd127;
  - field positions (CARRY_BIT=25, HIDDEN_BIT=24);
  - round-mode constants RUP=2'b00, RDOWN=2'b01, RTE=2'b10, RTAZ=2'b11 for the downstream stage.
- One sub-module fits naturally: fp32_lzc_window, a combinational leading-zero count of a STEP-bit window with saturation at STEP.

Test Plan:
- Normalized: in_mag=26'h1000000, exp=127, sign=0 -> at T+2: out_exp=127, out_m_norm=24'h000000, uf=0, of=0.
- Carry: in_mag=26'h3000001, exp=127 -> out_exp=128, out_m_norm=24'h800000 (round bit 0); out_valid at T+2.
- Left shift of 10, STEP=4: in_mag=26'h0004000, exp=100 -> shifts of 4, 4 and 2; out_exp=90, out_m_norm=24'h000000; out_valid at T+5.
- Subnormal clamp: in_mag=26'h0000100, exp=3 -> shift by 2, then stop; out_exp=0, out_m_norm=24'h000400, uf=1.
- Overflow: in_mag=26'h2000000, exp=254 -> out_exp=255, out_m_norm=0, of=1.
- Zero with backpressure and reset:
  - in_mag=0, exp=50 -> out_exp=0, m_norm=0, uf=0.
  - Hold out_ready=0 for 3 cycles: outputs stable, in_ready=0. Release: in_ready=1 one cycle after the handshake.
  - Then start in_mag=26'h0000001 and assert rst during SHIFT: all outputs return to reset values, and no out_valid pulse occurs.
